// File: rtl/scr1_tapc_sync_sampler_if.sv
`default_nettype none
// ============================================================================
// scr1_tapc_sync_sampler_if : TAPC <-> core scan-chain signal bundle
// Rev 1.0
// ============================================================================
interface scr1_tapc_sync_sampler_if #(
  parameter int CH_NUM   = 2,
  parameter int ID_WIDTH = 2
);
  logic                tck;
  logic [CH_NUM-1:0]   ch_sel;
  logic [ID_WIDTH-1:0] ch_id;
  logic                ch_capture;
  logic                ch_shift;
  logic                ch_update;
  logic                ch_tdi;
  logic                ch_tdo;
  logic [CH_NUM-1:0]   ch_sel_core;
  logic [ID_WIDTH-1:0] ch_id_core;
  logic                capture_core;
  logic                shift_core;
  logic                tdi_core;
  logic                update_core;
  logic                tdo_core;
  logic                err_clr;
  logic                tck_err;

  modport master (
    output tck, ch_sel, ch_id, ch_capture, ch_shift, ch_update, ch_tdi,
           tdo_core, err_clr,
    input  ch_tdo, ch_sel_core, ch_id_core, capture_core, shift_core,
           tdi_core, update_core, tck_err
  );

  modport slave (
    input  tck, ch_sel, ch_id, ch_capture, ch_shift, ch_update, ch_tdi,
           tdo_core, err_clr,
    output ch_tdo, ch_sel_core, ch_id_core, capture_core, shift_core,
           tdi_core, update_core, tck_err
  );
endinterface
`default_nettype wire

// File: rtl/scr1_tapc_sync_sampler.sv
`default_nettype none
// ============================================================================
// scr1_tapc_sync_sampler : oversampling TCK-domain -> SysCLK chain synchronizer
// Rev 1.0
// ============================================================================
module scr1_tapc_sync_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int CH_NUM      = 2,
  parameter int ID_WIDTH    = 2,
  parameter int MIN_HALF    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  scr1_tapc_sync_sampler_if.slave  tap
);
  localparam int DW    = 6 + CH_NUM + ID_WIDTH;
  localparam int CW    = $clog2(FILT_LEN + 1);
  localparam int B_VLD = 0;
  localparam int B_TCK = 1;
  localparam int B_CAP = 2;
  localparam int B_SHF = 3;
  localparam int B_UPD = 4;
  localparam int B_TDI = 5;
  localparam int B_SEL = 6;
  localparam int B_ID  = 6 + CH_NUM;
  localparam logic [CW-1:0] FILT_CNT = CW'(FILT_LEN);
  localparam logic [7:0]    MIN_GAP  = 8'(MIN_HALF);

  logic [DW-1:0]                   async_in;
  logic [SYNC_STAGES-1:0][DW-1:0]  sync_q;
  logic [DW-1:0]                   synced;
  logic                            sample_vld;
  logic                            sync_tck;

  logic                            filt_tck;
  logic                            armed;
  logic                            cand;
  logic [CW-1:0]                   cnt;
  logic [CW-1:0]                   cnt_inc;
  logic                            hit;
  logic                            accept;
  logic                            edge_acc;

  logic                            acc_q;
  logic                            rise_stb;
  logic                            fall_stb;
  logic [7:0]                      gap;
  logic                            viol;
  logic                            err_q;

  logic [CH_NUM-1:0]               sel_q;
  logic [ID_WIDTH-1:0]             id_q;
  logic                            cap_q;
  logic                            shf_q;
  logic                            tdi_q;
  logic                            upd_q;
  logic                            tdo_q;

  // Bit 0 is a constant 1 so the pipeline itself marks samples taken after reset.
  assign async_in   = {tap.ch_id, tap.ch_sel, tap.ch_tdi, tap.ch_update,
                       tap.ch_shift, tap.ch_capture, tap.tck, 1'b1};
  assign synced     = sync_q[SYNC_STAGES-1];
  assign sample_vld = synced[B_VLD];
  assign sync_tck   = synced[B_TCK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  // Unarmed: count equal consecutive samples of any level; armed: count samples away from filt_tck.
  always_comb begin
    hit     = 1'b0;
    cnt_inc = '0;
    if (armed) begin
      hit = (sync_tck != filt_tck);
    end else begin
      hit = (cnt == '0) || (sync_tck == cand);
    end
    if (hit) begin
      cnt_inc = cnt + 1'b1;
    end else if (!armed) begin
      cnt_inc = CW'(1);
    end
    accept   = sample_vld && (cnt_inc == FILT_CNT);
    edge_acc = accept && armed;
    viol     = edge_acc && (gap < MIN_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_tck <= 1'b0;
      armed    <= 1'b0;
      cand     <= 1'b0;
      cnt      <= '0;
    end else if (sample_vld) begin
      cand <= sync_tck;
      if (accept) begin
        filt_tck <= sync_tck;
        armed    <= 1'b1;
        cnt      <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      gap      <= 8'hFF;
      err_q    <= 1'b0;
    end else begin
      acc_q    <= edge_acc;
      rise_stb <= acc_q & filt_tck;
      fall_stb <= acc_q & ~filt_tck;
      if (edge_acc) begin
        gap <= 8'd0;
      end else if (gap != 8'hFF) begin
        gap <= gap + 8'd1;
      end
      err_q <= viol | (err_q & ~tap.err_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      id_q  <= '0;
      cap_q <= 1'b0;
      shf_q <= 1'b0;
      tdi_q <= 1'b0;
      upd_q <= 1'b0;
      tdo_q <= 1'b0;
    end else begin
      cap_q <= rise_stb & synced[B_CAP];
      shf_q <= rise_stb & synced[B_SHF];
      tdi_q <= rise_stb & synced[B_TDI];
      upd_q <= fall_stb & synced[B_UPD];
      if (rise_stb) begin
        sel_q <= synced[B_SEL +: CH_NUM];
        id_q  <= synced[B_ID +: ID_WIDTH];
      end
      if (fall_stb) begin
        tdo_q <= tap.tdo_core;
      end
    end
  end

  assign tap.ch_sel_core  = sel_q;
  assign tap.ch_id_core   = id_q;
  assign tap.capture_core = cap_q;
  assign tap.shift_core   = shf_q;
  assign tap.tdi_core     = tdi_q;
  assign tap.update_core  = upd_q;
  assign tap.ch_tdo       = tdo_q;
  assign tap.tck_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_scr1_tapc_sync_sampler.sv
`default_nettype none
// ============================================================================
// tb_scr1_tapc_sync_sampler : scoreboard bench with a sample-window reference model
// Rev 1.0
// ============================================================================
module tb_scr1_tapc_sync_sampler;
  localparam int S    = 2;
  localparam int F    = 2;
  localparam int CH   = 2;
  localparam int IDW  = 2;
  localparam int MINH = 6;
  localparam int W    = 6 + CH + IDW;
  localparam int MAXN = 400;

  typedef struct {
    int           n;
    logic [W-1:0] v;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scr1_tapc_sync_sampler_if #(.CH_NUM(CH), .ID_WIDTH(IDW)) tap ();

  scr1_tapc_sync_sampler #(
    .SYNC_STAGES (S),
    .FILT_LEN    (F),
    .CH_NUM      (CH),
    .ID_WIDTH    (IDW),
    .MIN_HALF    (MINH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tap   (tap)
  );

  // Stimulus plan: index n is the level presented at the n-th clk edge after reset release.
  logic            p_tck [0:MAXN];
  logic [CH-1:0]   p_sel [0:MAXN];
  logic [IDW-1:0]  p_id  [0:MAXN];
  logic            p_cap [0:MAXN];
  logic            p_shf [0:MAXN];
  logic            p_upd [0:MAXN];
  logic            p_tdi [0:MAXN];
  logic            p_tdo [0:MAXN];
  logic            p_clr [0:MAXN];

  exp_t         exp_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  int           edge_cnt    = 0;
  logic [W-1:0] mon_prev    = '0;
  logic [W-1:0] dut_v;

  assign dut_v = {tap.tck_err, tap.ch_tdo, tap.update_core, tap.tdi_core,
                  tap.shift_core, tap.capture_core, tap.ch_id_core, tap.ch_sel_core};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = '0;
      end else if (dut_v !== mon_prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change edge %0d: got %h, expected unchanged %h",
                   edge_cnt, dut_v, mon_prev);
        end else begin
          e = exp_q.pop_front();
          if (e.n != edge_cnt || e.v !== dut_v) begin
            miscompares++;
            $display("FAIL out_change: got %h at edge %0d, expected %h at edge %0d",
                     dut_v, edge_cnt, e.v, e.n);
          end
        end
        mon_prev = dut_v;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run still active, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: TCK accepted once the last F samples (seen S edges late) all differ from the
  // filtered level; the strobe follows one cycle later and core outputs load one cycle after that.
  task automatic model_segment(input int nn);
    logic                filt, armed, err, a1, a0, set;
    logic [MAXN+2:0]     acc_r, acc_f;
    logic [CH-1:0]       sel;
    logic [IDW-1:0]      id;
    logic                tdo, cap, shf, tdi, upd;
    logic [W-1:0]        cur, prev;
    int                  gap, hi, lo;
    exp_t                e;
    filt = 1'b0; armed = 1'b0; err = 1'b0; gap = 255;
    acc_r = '0; acc_f = '0; sel = '0; id = '0; tdo = 1'b0; prev = '0;
    for (int n = 1; n <= nn; n++) begin
      set = 1'b0;
      hi  = n - S;
      lo  = hi - F + 1;
      a1  = 1'b0;
      a0  = 1'b0;
      if (lo >= 1) begin
        a1 = 1'b1;
        a0 = 1'b1;
        for (int j = lo; j <= hi; j++) begin
          if (p_tck[j]) a0 = 1'b0;
          else          a1 = 1'b0;
        end
      end
      if (armed && (filt ? a0 : a1)) begin
        set      = (gap < MINH);
        gap      = 0;
        filt     = ~filt;
        acc_r[n] = filt;
        acc_f[n] = ~filt;
      end else begin
        if (!armed && (a1 || a0)) begin
          armed = 1'b1;
          filt  = a1;
        end
        gap = (gap < 255) ? gap + 1 : 255;
      end
      err = set | (err & ~p_clr[n]);
      cap = 1'b0; shf = 1'b0; tdi = 1'b0; upd = 1'b0;
      if (n >= 3 && acc_r[n-2]) begin
        cap = p_cap[n-S];
        shf = p_shf[n-S];
        tdi = p_tdi[n-S];
        sel = p_sel[n-S];
        id  = p_id[n-S];
      end
      if (n >= 3 && acc_f[n-2]) begin
        upd = p_upd[n-S];
        tdo = p_tdo[n];
      end
      cur = {err, tdo, upd, tdi, shf, cap, id, sel};
      if (cur != prev) begin
        e.n = n;
        e.v = cur;
        exp_q.push_back(e);
      end
      prev = cur;
    end
  endtask

  task automatic drive(input int n);
    tap.tck        = p_tck[n];
    tap.ch_sel     = p_sel[n];
    tap.ch_id      = p_id[n];
    tap.ch_capture = p_cap[n];
    tap.ch_shift   = p_shf[n];
    tap.ch_update  = p_upd[n];
    tap.ch_tdi     = p_tdi[n];
    tap.tdo_core   = p_tdo[n];
    tap.err_clr    = p_clr[n];
  endtask

  task automatic fill_random_data(input int nn);
    for (int n = 0; n <= nn; n++) begin
      p_sel[n] = CH'($urandom);
      p_id[n]  = IDW'($urandom);
      p_cap[n] = 1'($urandom);
      p_shf[n] = 1'($urandom);
      p_upd[n] = 1'($urandom);
      p_tdi[n] = 1'($urandom);
      p_tdo[n] = 1'($urandom);
      p_clr[n] = 1'b0;
      p_tck[n] = 1'b0;
    end
  endtask

  // Entered with reset asserted; leaves with reset asserted, possibly mid-transfer.
  task automatic run_segment(input int nn);
    model_segment(nn);
    drive(0);
    repeat (2) @(negedge clk);
    vectors++;
    if (dut_v !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h, expected %h", dut_v, {W{1'b0}});
    end
    drive(1);
    rst_n = 1'b1;
    for (int n = 2; n <= nn; n++) begin
      @(negedge clk);
      drive(n);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expect: got %0d outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    rst_n = 1'b0;
  endtask

  initial begin : stimulus
    logic lvl;
    int   n, run;
    fill_random_data(MAXN);
    drive(0);

    // TCK held high through and after reset: arming only, no output activity.
    fill_random_data(60);
    for (int i = 0; i <= 60; i++) p_tck[i] = 1'b1;
    run_segment(60);

    // Period 20 with shift/tdi held high.
    fill_random_data(140);
    for (int i = 0; i <= 140; i++) begin
      p_tck[i] = (i >= 15) ? (((i - 15) / 10) % 2 == 0) : 1'b0;
      p_shf[i] = 1'b1;
      p_tdi[i] = 1'b1;
    end
    run_segment(140);

    // Glitches shorter than the filter, one inside a high phase and one while low.
    fill_random_data(80);
    for (int i = 20; i <= 26; i++) p_tck[i] = 1'b1;
    p_tck[24] = 1'b0;
    p_tck[40] = 1'b1;
    for (int i = 50; i <= 59; i++) p_tck[i] = 1'b1;
    run_segment(80);

    // Half-period 4: timing violations, clear coincident with and apart from a violation.
    fill_random_data(100);
    for (int i = 0; i <= 100; i++) p_tck[i] = ((((i <= 70) ? i : 70) / 4) % 2) == 1;
    p_clr[43] = 1'b1;
    p_clr[45] = 1'b1;
    p_clr[90] = 1'b1;
    run_segment(100);

    // Random TCK run lengths, random data and clears; each ends in reset mid-activity.
    for (int seg = 0; seg < 4; seg++) begin
      fill_random_data(300);
      n   = 1;
      lvl = 1'($urandom);
      while (n <= 300) begin
        run = $urandom_range(1, 14);
        for (int k = 0; k < run && n <= 300; k++) begin
          p_tck[n] = lvl;
          n++;
        end
        lvl = ~lvl;
      end
      p_tck[0] = p_tck[1];
      for (int i = 1; i <= 300; i++) begin
        p_clr[i] = ($urandom_range(0, 15) == 0);
        if (seg == 3) p_shf[i] = 1'b1;
      end
      run_segment(300);
    end

    // After a mid-shift reset: fixed chain select/ID with TCK running.
    fill_random_data(120);
    for (int i = 0; i <= 120; i++) begin
      p_tck[i] = ((i / 6) % 2) == 1;
      p_sel[i] = 2'b01;
      p_id[i]  = 2'b10;
    end
    run_segment(120);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
